// File: rtl/aes_core_arbiter_if.sv
// rtl/aes_core_arbiter_if.sv - request/core handshake bundle for aes_core_arbiter
//
// Ports (signals):
//   enc_req, dec_req      requester levels, held until the matching ack
//   core_busy             AES core busy
//   err_clr               clears the sticky watchdog flag
//   core_start, core_mode start pulse and mode (1=encrypt) to the AES core
//   enc_ack, dec_ack      one-cycle accept pulses
//   enc_done, dec_done    one-cycle completion pulses
//   owner                 00 none, 01 enc, 10 dec
//   timeout_err           sticky watchdog flag
//   enc_blocks/dec_blocks completed-block counters
// Modports: master = requesters/core side, slave = arbiter.
interface aes_core_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             enc_req;
    logic             dec_req;
    logic             core_busy;
    logic             err_clr;
    logic             core_start;
    logic             core_mode;
    logic             enc_ack;
    logic             dec_ack;
    logic             enc_done;
    logic             dec_done;
    logic [1:0]       owner;
    logic             timeout_err;
    logic [CNT_W-1:0] enc_blocks;
    logic [CNT_W-1:0] dec_blocks;

    modport master (
        output enc_req, dec_req, core_busy, err_clr,
        input  core_start, core_mode, enc_ack, dec_ack, enc_done, dec_done,
        input  owner, timeout_err, enc_blocks, dec_blocks
    );

    modport slave (
        input  enc_req, dec_req, core_busy, err_clr,
        output core_start, core_mode, enc_ack, dec_ack, enc_done, dec_done,
        output owner, timeout_err, enc_blocks, dec_blocks
    );
endinterface

// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - round-robin arbiter/sequencer sharing one AES core between enc and dec paths
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  aes_core_arbiter_if.slave (requests, core handshake, acks, dones, owner, counters)
// Optional feature: AES_ARB_TIMEOUT_EN enables the RUN-state busy watchdog.
module aes_core_arbiter #(
    parameter int ARM_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_core_arbiter_if.slave     bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_ENC  = 2'b01;
    localparam logic [1:0] OWN_DEC  = 2'b10;

    state_t           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic             last_dec_q, last_dec_d;
    logic [3:0]       arm_q, arm_d;
    logic [CNT_W-1:0] enc_blocks_q, enc_blocks_d;
    logic [CNT_W-1:0] dec_blocks_q, dec_blocks_d;

`ifdef AES_ARB_TIMEOUT_EN
    logic [15:0]      wd_q, wd_d;
    logic             timeout_q, timeout_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_NONE;
            last_dec_q   <= 1'b1;       // enc wins the first tie
            arm_q        <= '0;
            enc_blocks_q <= '0;
            dec_blocks_q <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            wd_q         <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_dec_q   <= last_dec_d;
            arm_q        <= arm_d;
            enc_blocks_q <= enc_blocks_d;
            dec_blocks_q <= dec_blocks_d;
`ifdef AES_ARB_TIMEOUT_EN
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_dec_d   = last_dec_q;
        arm_d        = arm_q;
        enc_blocks_d = enc_blocks_q;
        dec_blocks_d = dec_blocks_q;
`ifdef AES_ARB_TIMEOUT_EN
        wd_d         = wd_q;
        // A trip later in this block overrides the clear, so set wins.
        timeout_d    = bus.err_clr ? 1'b0 : timeout_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                owner_d = OWN_NONE;
                // On a tie, serve whichever path was not served last.
                if (bus.enc_req && (!bus.dec_req || last_dec_q)) begin
                    owner_d    = OWN_ENC;
                    last_dec_d = 1'b0;
                    state_d    = S_START;
                end else if (bus.dec_req) begin
                    owner_d    = OWN_DEC;
                    last_dec_d = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                arm_d   = '0;
                state_d = S_ARM;
            end
            S_ARM: begin
                if (bus.core_busy) begin
`ifdef AES_ARB_TIMEOUT_EN
                    wd_d = '0;
`endif
                    state_d = S_RUN;
                end else if (arm_q == 4'(ARM_CYCLES - 1)) begin
                    // Busy never seen: the core finished in zero time.
                    state_d = S_DONE;
                end else begin
                    arm_d = arm_q + 4'd1;
                end
            end
            S_RUN: begin
                if (!bus.core_busy) begin
                    state_d = S_DONE;
                end
`ifdef AES_ARB_TIMEOUT_EN
                else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    owner_d   = OWN_NONE;
                    state_d   = S_IDLE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
`endif
            end
            S_DONE: begin
                if (owner_q == OWN_ENC) enc_blocks_d = enc_blocks_q + CNT_W'(1);
                if (owner_q == OWN_DEC) dec_blocks_d = dec_blocks_q + CNT_W'(1);
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end
        endcase
    end

    // Every output is a decode of registered state/owner.
    assign bus.core_start = (state_q == S_START);
    assign bus.core_mode  = (owner_q == OWN_ENC);
    assign bus.enc_ack    = (state_q == S_START) && (owner_q == OWN_ENC);
    assign bus.dec_ack    = (state_q == S_START) && (owner_q == OWN_DEC);
    assign bus.enc_done   = (state_q == S_DONE)  && (owner_q == OWN_ENC);
    assign bus.dec_done   = (state_q == S_DONE)  && (owner_q == OWN_DEC);
    assign bus.owner      = owner_q;
    assign bus.enc_blocks = enc_blocks_q;
    assign bus.dec_blocks = dec_blocks_q;

`ifdef AES_ARB_TIMEOUT_EN
    assign bus.timeout_err = timeout_q;
`else
    logic unused_err_clr;
    assign unused_err_clr  = bus.err_clr;
    assign bus.timeout_err = 1'b0;
`endif
endmodule
